kanagawa_multi_register_fifo: RTL and testbench
===============================================

# kanagawa_multi_register_fifo

Parametrised register-based FIFO with a show-ahead read port. Unlike the single-register variant, it sustains one write and one read every cycle with no stutter. It also provides real `usedw`, `almost_full` and `almost_empty` status. It is built from `DEPTH` flops with no RAM inference and is used for shallow elastic buffers between pipeline stages.

## Interface
- `WIDTH`, 32, data width in bits (≥1)
- `DEPTH`, 4, number of entries (≥2, any integer; power of two not required)
- `LOG_DEPTH`, `$clog2(DEPTH)`, pointer width
- `ALMOSTFULL_ENTRIES`, 1, `almost_full` asserts when `usedw >= DEPTH - ALMOSTFULL_ENTRIES`
- `USE_LUTRAM`, 0, accepted for interface compatibility and ignored
- `clock`  in  1  sole clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `wrreq`  in  1  write request
- `data`  in  WIDTH  write data
- `full`  out  1  no space left; registered
- `almost_full`  out  1  threshold flag; registered
- `usedw`  out  LOG_DEPTH+1  occupied entries, 0..DEPTH; registered
- `rdreq`  in  1  read/pop request
- `empty`  out  1  no data; registered
- `almost_empty`  out  1  `usedw <= 1`; registered
- `q`  out  WIDTH  head entry (show-ahead)
- `error`  out  1  sticky overflow/underflow flag; see Configuration

## Operation
- Storage is `mem[DEPTH]`, plus write pointer `wp`, read pointer `rp` and count `cnt`.
- **Write accepted** when `wrreq && !full`: `mem[wp] <= data`, and `wp` advances.
- **Read accepted** when `rdreq && !empty`, and `rp` advances.
- **Pointer wrap:** a pointer at `DEPTH-1` goes to 0. This rule covers non-power-of-two depths.
- **Count update:** `cnt_next = cnt + acc_wr - acc_rd`.
  - `full`, `empty`, `almost_full`, `almost_empty` and `usedw` are all registered from `cnt_next`.
  - There is no combinational path from `wrreq`/`rdreq` to any status output.
- **Simultaneous read and write:**
  - At `full`, only the read is accepted; the write is dropped. The next cycle has `cnt = DEPTH-1`.
  - At `empty`, only the write is accepted.
  - Otherwise both are accepted and `cnt` is unchanged.
- **Dropped requests:** a write while full or a read while empty is ignored. It does not touch storage, pointers or count.
- **`q` output:**
  - `q = mem[rp]` combinationally from storage.
  - It is valid only when `!empty`; when empty its value is don't-care.
  - `mem` is not reset.
- **Reset values:**
  - `wp = rp = cnt = 0`
  - `full = 0`, `empty = 1`, `almost_empty = 1`, `usedw = 0`
  - `almost_full = (ALMOSTFULL_ENTRIES >= DEPTH)`
  - `error = 0`
- **Reset mid-operation:** all contents are discarded in the cycle after `rst` is sampled high. `rst` takes precedence over concurrent `wrreq`/`rdreq`.

## Timing
- **Write-to-read latency:** 1 cycle. A write accepted at edge N gives `empty = 0` and valid `q` after edge N. A read may be accepted in that same following cycle.
- **Throughput:** 1 write and 1 read per cycle, sustained at any occupancy strictly between 0 and `DEPTH`.
- **Flag timing:** every status flag reflects all requests accepted up to and including the previous edge.
- **Upstream rule:** upstream must sample `full`/`almost_full` before driving `wrreq`. No write bypass exists when full.

## Configuration
- `KANAGAWA_FIFO_ERROR_CHECK_EN` defined:
  - `error` sets on any `wrreq && full` or `rdreq && empty`.
  - It stays set until `rst`.
  - A simulation-only assertion fires at the same event.
- Undefined: `error` is tied to 0, and neither the logic nor the assertion is compiled.

## Structure
- Shared package `kanagawa_fifo_pkg` holds:
  - the status-flag computation function (`cnt_next` to flag bundle), reused by the other FIFO variants;
  - the `fifo_status_t` struct for `full`, `almost_full`, `empty`, `almost_empty`;
  - the sticky-error helper.
- One sub-module, `kanagawa_wrap_counter` (parameters `MAX`, `WIDTH`): a pointer with increment enable and wrap at `MAX-1`. It is instantiated twice, for `wp` and `rp`.

## Test plan
- **Reset state:** after reset with `DEPTH=4`, `ALMOSTFULL_ENTRIES=1` → `empty=1`, `almost_empty=1`, `full=0`, `almost_full=0`, `usedw=0`, `error=0`.
- **Fill and drain:** write 0xA0..0xA3 on consecutive cycles → `almost_full` once `usedw=3`, `full` once `usedw=4`. A 5th write of 0xA4 is dropped. Draining 4 reads returns 0xA0..0xA3 in order, then `empty=1`. With the macro defined, `error=1` after the dropped write.
- **Full throughput:** sustain `wrreq=rdreq=1` for 20 cycles from `usedw=2` → `usedw` stays 2 and the output sequence matches the input exactly.
- **Non-power-of-two wrap:** `DEPTH=3`, 10 fill/drain rounds of 3 entries → no loss and correct order across pointer wrap from 2 to 0.
- **Boundary simultaneity:**
  - At `full`, with `wrreq=rdreq=1`, one read occurs and `usedw` becomes 3.
  - At `empty`, with `wrreq=rdreq=1` and `data=0x55`, `usedw` becomes 1 and `q=0x55` next cycle.
- **Reset mid-operation:** at `usedw=3`, assert `rst` together with `wrreq` → next cycle `usedw=0` and `empty=1`. A subsequent write of 0x77 is read back as 0x77.

Source files
------------

// File: rtl/kanagawa_fifo_pkg.sv
// Shared helpers for the kanagawa FIFO family: status flag bundle, flag
// computation from the next occupancy count, and the sticky error update.
package kanagawa_fifo_pkg;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
  } fifo_status_t;

  // Flags derive purely from the post-update count so they can be registered.
  function automatic fifo_status_t calc_status(input int cnt_next,
                                               input int depth,
                                               input int almostfull_entries);
    fifo_status_t s;
    s.full         = (cnt_next >= depth);
    s.almost_full  = (cnt_next + almostfull_entries >= depth);
    s.empty        = (cnt_next == 0);
    s.almost_empty = (cnt_next <= 1);
    return s;
  endfunction

  function automatic logic sticky_error(input logic err_q,
                                        input logic overflow,
                                        input logic underflow);
    return err_q | overflow | underflow;
  endfunction

endpackage

// File: rtl/kanagawa_multi_register_fifo_if.sv
// Write/read/status bundle of the multi-register FIFO; the FIFO takes the
// slave modport, the surrounding pipeline stages the master modport.
interface kanagawa_multi_register_fifo_if #(
  parameter int WIDTH     = 32,
  parameter int LOG_DEPTH = 2
);
  logic                 wrreq;
  logic [WIDTH-1:0]     data;
  logic                 full;
  logic                 almost_full;
  logic [LOG_DEPTH:0]   usedw;
  logic                 rdreq;
  logic                 empty;
  logic                 almost_empty;
  logic [WIDTH-1:0]     q;
  logic                 error;

  modport master (
    output wrreq, data, rdreq,
    input  full, almost_full, usedw, empty, almost_empty, q, error
  );

  modport slave (
    input  wrreq, data, rdreq,
    output full, almost_full, usedw, empty, almost_empty, q, error
  );
endinterface

// File: rtl/kanagawa_wrap_counter.sv
// Pointer with increment enable that wraps from MAX-1 back to 0, so it works
// for depths that are not a power of two.
module kanagawa_wrap_counter #(
  parameter int MAX   = 4,
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clock) begin
    if (rst) begin
      value <= '0;
    end else if (inc) begin
      value <= (value == WIDTH'(MAX - 1)) ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/kanagawa_multi_register_fifo.sv
// Flop-based show-ahead FIFO sustaining one write and one read per cycle.
// Optional sticky error flag enabled by KANAGAWA_FIFO_ERROR_CHECK_EN.
module kanagawa_multi_register_fifo
  import kanagawa_fifo_pkg::*;
#(
  parameter int WIDTH              = 32,
  parameter int DEPTH              = 4,
  parameter int LOG_DEPTH          = $clog2(DEPTH),
  parameter int ALMOSTFULL_ENTRIES = 1,
  parameter int USE_LUTRAM         = 0
) (
  input  logic clock,
  input  logic rst,
  kanagawa_multi_register_fifo_if.slave bus
);

  localparam int CntW = LOG_DEPTH + 1;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [LOG_DEPTH-1:0] wp;
  logic [LOG_DEPTH-1:0] rp;
  logic [CntW-1:0]      cnt;
  logic [CntW-1:0]      cnt_next;
  fifo_status_t         status;
  logic                 acc_wr;
  logic                 acc_rd;

  // Storage is always flops here; the LUTRAM hint has no effect.
  if (USE_LUTRAM != 0) begin : g_lutram_hint_ignored
  end

  assign acc_wr = bus.wrreq && !status.full;
  assign acc_rd = bus.rdreq && !status.empty;

  always_comb begin
    cnt_next = cnt + CntW'(acc_wr) - CntW'(acc_rd);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      cnt    <= '0;
      status <= calc_status(0, DEPTH, ALMOSTFULL_ENTRIES);
    end else begin
      cnt    <= cnt_next;
      status <= calc_status(int'(cnt_next), DEPTH, ALMOSTFULL_ENTRIES);
    end
  end

  // Contents are deliberately left unreset; q is only meaningful when not empty.
  always_ff @(posedge clock) begin
    if (acc_wr) begin
      mem[wp] <= bus.data;
    end
  end

  kanagawa_wrap_counter #(.MAX(DEPTH), .WIDTH(LOG_DEPTH)) u_wp (
    .clock (clock),
    .rst   (rst),
    .inc   (acc_wr),
    .value (wp)
  );

  kanagawa_wrap_counter #(.MAX(DEPTH), .WIDTH(LOG_DEPTH)) u_rp (
    .clock (clock),
    .rst   (rst),
    .inc   (acc_rd),
    .value (rp)
  );

  assign bus.q            = mem[rp];
  assign bus.usedw        = cnt;
  assign bus.full         = status.full;
  assign bus.almost_full  = status.almost_full;
  assign bus.empty        = status.empty;
  assign bus.almost_empty = status.almost_empty;

`ifdef KANAGAWA_FIFO_ERROR_CHECK_EN
  logic error_q;

  always_ff @(posedge clock) begin
    if (rst) begin
      error_q <= 1'b0;
    end else begin
      error_q <= sticky_error(error_q, bus.wrreq && status.full,
                              bus.rdreq && status.empty);
    end
  end

  assign bus.error = error_q;

  a_no_overflow_underflow : assert property (
    @(posedge clock) disable iff (rst)
      !((bus.wrreq && status.full) || (bus.rdreq && status.empty))
  );
`else
  assign bus.error = 1'b0;
`endif

endmodule

// File: tb/tb_kanagawa_multi_register_fifo.sv
// Randomized and directed bench for kanagawa_multi_register_fifo (DEPTH 4 and
// DEPTH 3 instances) against a queue-based reference model.
module tb_kanagawa_multi_register_fifo;

  logic clock = 1'b0;
  logic rst4  = 1'b1;
  logic rst3  = 1'b1;

  always #5 clock = ~clock;

  kanagawa_multi_register_fifo_if #(.WIDTH(32), .LOG_DEPTH(2)) bus4 ();
  kanagawa_multi_register_fifo_if #(.WIDTH(32), .LOG_DEPTH(2)) bus3 ();

  kanagawa_multi_register_fifo #(.WIDTH(32), .DEPTH(4)) dut4 (
    .clock (clock),
    .rst   (rst4),
    .bus   (bus4)
  );

  kanagawa_multi_register_fifo #(.WIDTH(32), .DEPTH(3)) dut3 (
    .clock (clock),
    .rst   (rst3),
    .bus   (bus3)
  );

  logic [31:0] model[$];
  logic        model_err;
  int          check_count = 0;
  int          fail_count  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    check_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle on the selected FIFO (0: depth 4, 1: depth 3), holds the
  // other in reset, then compares every output with the queue model.
  task automatic applyStimulus(input int sel, input logic rst_v, input logic wr,
                               input logic rd, input logic [31:0] d);
    int depth;
    logic full_b, empty_b;
    logic [31:0] o_usedw, o_q;
    logic o_full, o_afull, o_empty, o_aempty, o_err;
    depth   = (sel == 0) ? 4 : 3;
    full_b  = (model.size() == depth);
    empty_b = (model.size() == 0);
    if (sel == 0) begin
      rst4 = rst_v; bus4.wrreq = wr; bus4.rdreq = rd; bus4.data = d;
      rst3 = 1'b1;  bus3.wrreq = 1'b0; bus3.rdreq = 1'b0; bus3.data = '0;
    end else begin
      rst3 = rst_v; bus3.wrreq = wr; bus3.rdreq = rd; bus3.data = d;
      rst4 = 1'b1;  bus4.wrreq = 1'b0; bus4.rdreq = 1'b0; bus4.data = '0;
    end
    @(posedge clock);
    #1;
    if (rst_v) begin
      model.delete();
      model_err = 1'b0;
    end else begin
`ifdef KANAGAWA_FIFO_ERROR_CHECK_EN
      if ((wr && full_b) || (rd && empty_b)) model_err = 1'b1;
`endif
      if (rd && !empty_b) void'(model.pop_front());
      if (wr && !full_b) model.push_back(d);
    end
    if (sel == 0) begin
      o_usedw = 32'(bus4.usedw); o_q = bus4.q; o_full = bus4.full;
      o_afull = bus4.almost_full; o_empty = bus4.empty;
      o_aempty = bus4.almost_empty; o_err = bus4.error;
    end else begin
      o_usedw = 32'(bus3.usedw); o_q = bus3.q; o_full = bus3.full;
      o_afull = bus3.almost_full; o_empty = bus3.empty;
      o_aempty = bus3.almost_empty; o_err = bus3.error;
    end
    checkOutput("usedw", o_usedw, 32'(model.size()));
    checkOutput("full", 32'(o_full), 32'(model.size() == depth));
    checkOutput("almost_full", 32'(o_afull), 32'(model.size() >= depth - 1));
    checkOutput("empty", 32'(o_empty), 32'(model.size() == 0));
    checkOutput("almost_empty", 32'(o_aempty), 32'(model.size() <= 1));
    checkOutput("error", 32'(o_err), 32'(model_err));
    if (model.size() != 0) checkOutput("q", o_q, model[0]);
  endtask

  task automatic randomPhase(input int sel, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      applyStimulus(sel, 1'b0, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom);
    end
  endtask

  initial begin
    model_err = 1'b0;
    bus4.wrreq = 1'b0; bus4.rdreq = 1'b0; bus4.data = '0;
    bus3.wrreq = 1'b0; bus3.rdreq = 1'b0; bus3.data = '0;

    // Depth 4: reset state, fill/drain with dropped overflow write.
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1'b0, 1'b1, 1'b0, 32'hA0 + i);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1'b0, 1'b0, 1'b1, 32'h0);

    // Sustained simultaneous traffic from occupancy 2.
    applyStimulus(0, 1'b0, 1'b1, 1'b0, $urandom);
    applyStimulus(0, 1'b0, 1'b1, 1'b0, $urandom);
    for (int i = 0; i < 20; i++) applyStimulus(0, 1'b0, 1'b1, 1'b1, $urandom);

    // Simultaneous read/write at full, then at empty.
    applyStimulus(0, 1'b0, 1'b1, 1'b0, $urandom);
    applyStimulus(0, 1'b0, 1'b1, 1'b0, $urandom);
    applyStimulus(0, 1'b0, 1'b1, 1'b1, 32'hDEAD);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, 1'b0, 1'b1, 32'h0);
    applyStimulus(0, 1'b0, 1'b1, 1'b1, 32'h55);
    applyStimulus(0, 1'b0, 1'b0, 1'b1, 32'h0);

    // Reset mid-operation with a concurrent write.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, 1'b1, 1'b0, $urandom);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h99);
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 32'h77);
    applyStimulus(0, 1'b0, 1'b0, 1'b1, 32'h0);

    randomPhase(0, 150);

    // Depth 3: wrap across a non-power-of-two pointer range.
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 3; i++) applyStimulus(1, 1'b0, 1'b1, 1'b0, $urandom);
      for (int i = 0; i < 3; i++) applyStimulus(1, 1'b0, 1'b0, 1'b1, 32'h0);
    end
    randomPhase(1, 150);

    $display("%0d/%0d checks passed", check_count - fail_count, check_count);
    $finish;
  end

endmodule
